// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the 8-bit memory bus: the core (port 0) and a DMA/debug engine (port 1).
// The grant parks on the last owner, alternates after completed accesses, and honours bounded locks.
module mem_bus_arbiter #(
  parameter logic [15:0] SLOW_BASE = 16'hF000,
  parameter int unsigned SLOW_WS   = 2,
  parameter int unsigned LOCK_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic        m0_lock,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_outdata,
  output logic [7:0]  m0_indata,
  output logic        m0_wait,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic        m1_lock,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_outdata,
  output logic [7:0]  m1_indata,
  output logic        m1_wait,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_outdata,
  input  logic [7:0]  mem_indata,
  input  logic        mem_wait,
  output logic        owner
);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} state_t;

  localparam logic [3:0] WS_TGT   = 4'(SLOW_WS);
  localparam logic [7:0] LOCK_TGT = 8'(LOCK_MAX);
  localparam logic       SLOW_EN  = (SLOW_WS != 0);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  ws_cnt;
  logic [3:0]  ws_nx;
  logic [7:0]  lock_cnt;
  logic [7:0]  lock_nx;

  logic        sel_req;
  logic        sel_wr;
  logic        sel_lock;
  logic [15:0] sel_addr;
  logic [7:0]  sel_outdata;
  logic        oth_req;
  logic        slow;
  logic        sel_wait;
  logic        done;
  logic        handover;

  // Owner-side view of the bus.
  always_comb begin
    sel_req     = m0_req;
    sel_wr      = m0_wr;
    sel_lock    = m0_lock;
    sel_addr    = m0_addr;
    sel_outdata = m0_outdata;
    oth_req     = m1_req;
    if (state == OWN1) begin
      sel_req     = m1_req;
      sel_wr      = m1_wr;
      sel_lock    = m1_lock;
      sel_addr    = m1_addr;
      sel_outdata = m1_outdata;
      oth_req     = m0_req;
    end
  end

  // Handshake: a requester holds req (and its addr/wr/data) while its wait is 1;
  // the access completes on the rising edge where req=1 and wait=0.
  always_comb begin
    slow     = sel_req & (sel_addr >= SLOW_BASE) & SLOW_EN;
    sel_wait = mem_wait | (slow & (ws_cnt != WS_TGT));
    done     = sel_req & ~sel_wait;
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_outdata = 8'h00;
    m0_indata   = 8'h00;
    m1_indata   = 8'h00;
    m0_wait     = 1'b1;
    m1_wait     = 1'b1;
    if (!rst) begin
      mem_req     = sel_req;
      mem_wr      = sel_wr & sel_req;
      mem_addr    = sel_addr;
      mem_outdata = sel_outdata;
      if (state == OWN1) begin
        m1_indata = mem_indata;
        m1_wait   = sel_wait;
      end else begin
        m0_indata = mem_indata;
        m0_wait   = sel_wait;
      end
    end
  end

  assign owner = state;

  // Grant decision, lock budget and wait-state counter.
  always_comb begin
    handover = 1'b0;
    state_nx = state;
    lock_nx  = lock_cnt;
    ws_nx    = ws_cnt;

    if (!sel_req && oth_req) begin
      handover = 1'b1;
    end else if (done && oth_req) begin
      if (!sel_lock || (lock_cnt + 8'd1 >= LOCK_TGT)) begin
        handover = 1'b1;
      end else begin
        lock_nx = lock_cnt + 8'd1;
      end
    end

    if (handover) begin
      state_nx = (state == OWN0) ? OWN1 : OWN0;
    end

    if (handover || !oth_req) begin
      lock_nx = 8'd0;
    end

    // An abandoned access (req dropped) restarts its wait-state count too.
    if (handover || done || !sel_req) begin
      ws_nx = 4'd0;
    end else if (slow && (ws_cnt != WS_TGT)) begin
      ws_nx = ws_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OWN0;
      ws_cnt   <= 4'd0;
      lock_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      ws_cnt   <= ws_nx;
      lock_cnt <= lock_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with SLOW_WS=2 and LOCK_MAX=3.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wr, m0_lock;
  logic [15:0] m0_addr;
  logic [7:0]  m0_outdata, m0_indata;
  logic        m0_wait;
  logic        m1_req, m1_wr, m1_lock;
  logic [15:0] m1_addr;
  logic [7:0]  m1_outdata, m1_indata;
  logic        m1_wait;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_outdata, mem_indata;
  logic        mem_wait;
  logic        owner;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  mem_bus_arbiter #(.SLOW_BASE(16'hF000), .SLOW_WS(2), .LOCK_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_outdata(m0_outdata), .m0_indata(m0_indata), .m0_wait(m0_wait),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_outdata(m1_outdata), .m1_indata(m1_indata), .m1_wait(m1_wait),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_outdata(mem_outdata), .mem_indata(mem_indata), .mem_wait(mem_wait),
    .owner(owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic wr, input logic [15:0] addr, input logic [7:0] data);
    m0_req = req; m0_wr = wr; m0_addr = addr; m0_outdata = data;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [15:0] addr, input logic [7:0] data);
    m1_req = req; m1_wr = wr; m1_addr = addr; m1_outdata = data;
  endtask

  initial begin
    rst = 1'b1;
    m0_lock = 1'b0; m1_lock = 1'b0;
    drive0(1'b1, 1'b1, 16'h1234, 8'h77);
    drive1(1'b0, 1'b0, 16'h0000, 8'h00);
    mem_indata = 8'hAA; mem_wait = 1'b0;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_m0_wait", m0_wait, 1);
    check("rst_m1_wait", m1_wait, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_outdata", mem_outdata, 0);
    check("rst_m0_indata", m0_indata, 0);
    check("rst_owner", owner, 0);

    // core only, fast region
    step();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 16'h0004, 8'h00);
    mem_indata = 8'h5A;
    #1;
    check("fast_m0_wait", m0_wait, 0);
    check("fast_m0_indata", m0_indata, 8'h5A);
    check("fast_m1_indata", m1_indata, 0);
    check("fast_m1_wait", m1_wait, 1);
    check("fast_mem_addr", mem_addr, 16'h0004);
    step();
    drive0(1'b1, 1'b1, 16'h0005, 8'hC3);
    #1;
    check("fast_wr_mem_wr", mem_wr, 1);
    check("fast_wr_outdata", mem_outdata, 8'hC3);
    check("fast_wr_wait", m0_wait, 0);
    check("fast_owner", owner, 0);
    step();
    drive0(1'b1, 1'b0, 16'h0006, 8'h00);
    mem_wait = 1'b1;
    #1;
    check("memwait_m0_wait", m0_wait, 1);
    step();
    mem_wait = 1'b0;
    drive0(1'b1, 1'b0, 16'hEFFF, 8'h00);
    #1;
    check("below_base_wait", m0_wait, 0);

    // slow region: two extra wait cycles
    step();
    drive0(1'b1, 1'b0, 16'hF010, 8'h00);
    #1;
    check("slow_c1_wait", m0_wait, 1);
    check("slow_c1_req", mem_req, 1);
    step();
    #1;
    check("slow_c2_wait", m0_wait, 1);
    check("slow_c2_req", mem_req, 1);
    step();
    #1;
    check("slow_c3_wait", m0_wait, 0);
    check("slow_c3_req", mem_req, 1);
    step();
    drive0(1'b1, 1'b0, 16'h0004, 8'h00);
    #1;
    check("slow_ws_clear", dut.ws_cnt, 0);
    check("after_slow_fast_wait", m0_wait, 0);

    // contention: owner alternates every clock, parked owner wins first
    step();
    drive0(1'b1, 1'b0, 16'h0010, 8'h00);
    drive1(1'b1, 1'b0, 16'h0020, 8'h00);
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 1) ? 16'h0020 : 16'h0010);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] e;
      logic        eo;
      if (i > 0) step();
      #1;
      e  = exp_q.pop_front();
      eo = (e == 16'h0020);
      check("cont_owner", owner, eo);
      check("cont_mem_addr", mem_addr, e);
      check("cont_mem_req", mem_req, 1);
      check("cont_nonowner_wait", eo ? m0_wait : m1_wait, 1);
      check("cont_owner_wait", eo ? m1_wait : m0_wait, 0);
    end

    // parked switch: one bubble, then m1 slow access blocks m0
    step();
    drive0(1'b0, 1'b0, 16'h0010, 8'h00);
    drive1(1'b1, 1'b0, 16'hF100, 8'h00);
    #1;
    check("park_owner", owner, 0);
    check("park_bubble_req", mem_req, 0);
    check("park_m1_wait", m1_wait, 1);
    step();
    m0_req = 1'b1;
    #1;
    check("park_new_owner", owner, 1);
    check("park_m1_c1_wait", m1_wait, 1);
    check("park_m0_blocked", m0_wait, 1);
    step();
    #1;
    check("park_hold_owner", owner, 1);
    check("park_m1_c2_wait", m1_wait, 1);
    step();
    #1;
    check("park_m1_done", m1_wait, 0);
    step();
    m1_req = 1'b0;
    #1;
    check("park_back_owner", owner, 0);
    check("park_m0_done", m0_wait, 0);

    // lock with LOCK_MAX=3
    step();
    drive0(1'b0, 1'b0, 16'h0010, 8'h00);
    drive1(1'b1, 1'b1, 16'h0030, 8'h11);
    m1_lock = 1'b1;
    #1;
    check("lock_bubble_req", mem_req, 0);
    step();
    m0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      check("lock_owner", owner, 1);
      check("lock_m1_wait", m1_wait, 0);
      check("lock_m0_wait", m0_wait, 1);
      check("lock_cnt", dut.lock_cnt, i);
    end
    step();
    #1;
    check("lock_forced_owner", owner, 0);
    check("lock_m0_done", m0_wait, 0);
    check("lock_cnt_clear", dut.lock_cnt, 0);

    // async reset mid slow access on port 1
    step();
    m1_lock = 1'b0;
    drive0(1'b0, 1'b0, 16'h0010, 8'h00);
    drive1(1'b1, 1'b0, 16'hF200, 8'h00);
    #1;
    check("ar_owner", owner, 1);
    check("ar_c1_wait", m1_wait, 1);
    step();
    #1;
    check("ar_ws_cnt", dut.ws_cnt, 1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_mem_req", mem_req, 0);
    check("ar_m0_wait", m0_wait, 1);
    check("ar_m1_wait", m1_wait, 1);
    check("ar_m1_indata", m1_indata, 0);
    check("ar_owner_rst", owner, 0);
    check("ar_ws_rst", dut.ws_cnt, 0);
    #1;
    rst = 1'b0;
    drive1(1'b0, 1'b0, 16'h0000, 8'h00);
    drive0(1'b1, 1'b0, 16'h0008, 8'h00);
    mem_indata = 8'h3C;
    #1;
    check("ar_post_owner", owner, 0);
    check("ar_post_wait", m0_wait, 0);
    check("ar_post_indata", m0_indata, 8'h3C);
    step();
    #1;
    check("ar_post_hold", owner, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
